pipo_ctr_controller: RTL and testbench
======================================

PIPO_CTR_CONTROLLER -- requirements
Module: pipo_ctr_controller

Interface
REQ-001 Parameter PIPE_LAT, 13, cycles from core input capture to matching core_result.
REQ-002 Parameter OFIFO_DEPTH, 16, output FIFO entries (power of two, >= PIPE_LAT).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_load  input  1  load-key/IV pulse; accepted only in IDLE or READY.
REQ-006 key_in  input  128 (roundKey_t)  master key.
REQ-007 iv_in  input  64 (state_t)  initial counter value.
REQ-008 in_valid / in_ready  input / output  1 / 1  block-input handshake.
REQ-009 in_data  input  64  block to process.
REQ-010 in_last  input  1  final block of the message.
REQ-011 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-012 out_data  output  64  core result.
REQ-013 out_last  output  1  marks the result of the in_last block.
REQ-014 core_data, core_counter  output  64 each  drive core data and counter inputs.
REQ-015 core_key  output  128  drives core key input.
REQ-016 core_result  input  64  core output.
REQ-017 busy  output  1  high when any block is in flight or buffered.

Function
REQ-018 FSM states: IDLE (no key), READY (key valid, idle), RUN, DRAIN.
REQ-019 IDLE->READY on key_load; READY->RUN on first accepted block; RUN->DRAIN on an accepted block with in_last=1.
REQ-020 DRAIN->READY when in-flight count = 0 and FIFO empty; the last out_last pop completes the drain.
REQ-021 key_load in READY reloads key and counter; key_load in RUN/DRAIN is ignored.
REQ-022 On key_load: key register <= key_in, counter <= iv_in.
REQ-023 in_ready = (state is READY or RUN) AND (fifo_count + inflight < OFIFO_DEPTH).
REQ-024 Transfer on in_valid & in_ready: core_data <= in_data, core_counter <= counter, and counter increments by 1 the same edge.
REQ-025 Counter is 64-bit modulo: 0xFFFF_FFFF_FFFF_FFFF + 1 = 0; no flag.
REQ-026 core_key holds the key register constantly; it does not change while inflight > 0.
REQ-027 A PIPE_LAT-deep shift register of {valid, last} tags tracks each issued block; when a tag exits, core_result and last are pushed into the FIFO.
REQ-028 The credit rule (REQ-023) guarantees that no push ever finds the FIFO full; the core pipeline is never stalled.
REQ-029 A push and a pop in the same cycle leave fifo_count unchanged.
REQ-030 out_valid = FIFO not empty; out_data/out_last come from the head; pop on out_valid & out_ready.
REQ-031 Results leave in issue order; latency from in-transfer to earliest out_valid is PIPE_LAT+1 cycles.
REQ-032 core_data/core_counter hold their last values when nothing is issued (tag valid=0 marks the bubble).

Reset
REQ-033 reset forces state=IDLE, counter=0, key=0, tags=0, FIFO empty, inflight=0.
REQ-034 After reset, outputs: in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, core_*=0.
REQ-035 reset mid-operation discards all in-flight and buffered blocks; no stale out_valid follows.

Structure
REQ-036 PIPODefinitions gains PIPE_LAT, OFIFO_DEPTH, and ctrl_state_t (IDLE, READY, RUN, DRAIN); state_t/roundKey_t are reused.
REQ-037 One sub-module: pipo_out_fifo (synchronous FIFO, 65-bit entries {last, data}, count output).
REQ-038 The cipher core is instantiated outside this block; this block only drives and samples it.

Verification
REQ-039 Key load with iv=0x0000_0000_0000_00FE, then 3 back-to-back blocks -> core_counter 0xFE, 0xFF, 0x100; outputs at cycles +14, +15, +16 in order.
REQ-040 iv=0xFFFF_FFFF_FFFF_FFFF, 2 blocks -> core_counter 0xFFFF_FFFF_FFFF_FFFF then 0x0.
REQ-041 out_ready=0, 40 blocks offered -> exactly 16 accepted, in_ready low after that, no FIFO overflow; releasing out_ready returns all 16 in order.
REQ-042 5 blocks, last with in_last=1 -> state DRAIN, in_ready=0, out_last only on 5th output, then READY.
REQ-043 key_load during RUN -> key and counter unchanged; during READY -> reloaded.
REQ-044 reset asserted 5 cycles after issuing 4 blocks -> no out_valid in the next 20 cycles; all outputs at reset values.

Source files
------------

// File: rtl/pipo_ctr_controller_pkg.sv
// Shared PIPO types plus the counter-mode controller's sizing constants and state encoding.
package PIPODefinitions;

  typedef logic [63:0]  state_t;
  typedef logic [127:0] roundKey_t;

  localparam int PIPE_LAT    = 13;
  localparam int OFIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    RUN,
    DRAIN
  } ctrl_state_t;

endpackage

// File: rtl/pipo_ctr_controller_out_fifo.sv
// Synchronous result FIFO holding {last, data}; reads as zero while empty.
module pipo_out_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 65
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign do_push  = push && (count != CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipo_ctr_controller.sv
// Counter-mode sequencer around an external fixed-latency PIPO core: issues blocks,
// tracks them with a tag pipe and buffers results in a credit-protected output FIFO.
//
//   state | meaning
//   IDLE  | no key loaded, inputs refused
//   READY | key valid, nothing in progress
//   RUN   | accepting blocks of a message
//   DRAIN | last block accepted, waiting for pipe and FIFO to empty
module pipo_ctr_controller
  import PIPODefinitions::*;
#(
  parameter int PIPE_LAT    = PIPODefinitions::PIPE_LAT,
  parameter int OFIFO_DEPTH = PIPODefinitions::OFIFO_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      key_load,
  input  roundKey_t key_in,
  input  state_t    iv_in,
  input  logic      in_valid,
  output logic      in_ready,
  input  state_t    in_data,
  input  logic      in_last,
  output logic      out_valid,
  input  logic      out_ready,
  output state_t    out_data,
  output logic      out_last,
  output state_t    core_data,
  output state_t    core_counter,
  output roundKey_t core_key,
  input  state_t    core_result,
  output logic      busy
);

  localparam int CW = $clog2(OFIFO_DEPTH + 1);
  localparam int IW = $clog2(PIPE_LAT + 1);

  ctrl_state_t         state, state_nxt;
  roundKey_t           key_q;
  state_t              counter;
  logic [PIPE_LAT-1:0] tag_v;
  logic [PIPE_LAT-1:0] tag_l;
  logic [IW-1:0]       inflight;
  logic [CW-1:0]       fifo_count;
  logic [CW:0]         credit_used;
  logic                fifo_empty;
  logic                xfer;
  logic                push;
  logic                pop;
  logic                load_key;
  logic [64:0]         fifo_rd;

  assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(inflight);
  assign in_ready    = ((state == READY) || (state == RUN)) &&
                       (credit_used < (CW+1)'(OFIFO_DEPTH));
  assign xfer        = in_valid && in_ready;
  // A block offered alongside key_load in READY wins; the key only moves with nothing in flight.
  assign load_key    = key_load && ((state == IDLE) || ((state == READY) && !xfer));
  assign push        = tag_v[PIPE_LAT-1];
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign {out_last, out_data} = fifo_rd;
  assign core_key    = key_q;
  assign busy        = (inflight != '0) || !fifo_empty;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_load) state_nxt = READY;
      READY:   if (xfer) state_nxt = in_last ? DRAIN : RUN;
      RUN:     if (xfer && in_last) state_nxt = DRAIN;
      DRAIN:   if ((inflight == '0) && fifo_empty) state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      key_q        <= '0;
      counter      <= '0;
      core_data    <= '0;
      core_counter <= '0;
      tag_v        <= '0;
      tag_l        <= '0;
      inflight     <= '0;
    end else begin
      state <= state_nxt;
      tag_v <= {tag_v[PIPE_LAT-2:0], xfer};
      tag_l <= {tag_l[PIPE_LAT-2:0], xfer && in_last};
      if (load_key) begin
        key_q   <= key_in;
        counter <= iv_in;
      end else if (xfer) begin
        core_data    <= in_data;
        core_counter <= counter;
        counter      <= counter + 64'd1;
      end
      case ({xfer, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  pipo_out_fifo #(
    .DEPTH (OFIFO_DEPTH),
    .WIDTH (65)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({tag_l[PIPE_LAT-1], core_result}),
    .pop       (pop),
    .pop_data  (fifo_rd),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_pipo_ctr_controller.sv
// Directed bench for pipo_ctr_controller with a behavioural fixed-latency core model.
module tb_pipo_ctr_controller;
  import PIPODefinitions::*;

  localparam int LAT   = 13;
  localparam int DEPTH = 16;

  logic      clk = 1'b0;
  logic      reset;
  logic      key_load;
  roundKey_t key_in;
  state_t    iv_in;
  logic      in_valid;
  logic      in_ready;
  state_t    in_data;
  logic      in_last;
  logic      out_valid;
  logic      out_ready;
  state_t    out_data;
  logic      out_last;
  state_t    core_data;
  state_t    core_counter;
  roundKey_t core_key;
  state_t    core_result;
  logic      busy;

  pipo_ctr_controller dut (
    .clk          (clk),
    .reset        (reset),
    .key_load     (key_load),
    .key_in       (key_in),
    .iv_in        (iv_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .core_data    (core_data),
    .core_counter (core_counter),
    .core_key     (core_key),
    .core_result  (core_result),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: result for the block on core_data appears LAT-1 edges after it is presented.
  state_t core_pipe [LAT-1];
  always @(posedge clk) begin
    core_pipe[0] <= core_data ^ core_counter ^ core_key[63:0];
    for (int i = 1; i < LAT - 1; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_result = core_pipe[LAT-2];

  typedef struct {
    state_t data;
    logic   last;
    int     t_edge;
  } exp_t;

  exp_t      sb[$];
  exp_t      mon_e;
  int        n_checks = 0;
  int        n_errors = 0;
  logic      chk_lat  = 1'b0;
  roundKey_t exp_key;
  state_t    exp_ctr;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", out_data, mon_e.data);
        chk("out_last", out_last, mon_e.last);
        if (chk_lat) chk("latency", cyc - mon_e.t_edge + 1, LAT + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input roundKey_t k, input state_t iv);
    key_load = 1'b1;
    key_in   = k;
    iv_in    = iv;
    tick();
    key_load = 1'b0;
  endtask

  task automatic send(input state_t d, input logic last);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      chk("send_timeout", 1, 0);
      in_valid = 1'b0;
      return;
    end
    tick();
    sb.push_back('{data: d ^ exp_ctr ^ exp_key[63:0], last: last, t_edge: cyc});
    chk("core_data", core_data, d);
    chk("core_counter", core_counter, exp_ctr);
    chk("core_key", core_key, exp_key);
    exp_ctr = exp_ctr + 64'd1;
  endtask

  task automatic wait_idle();
    int w = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    while ((busy || out_valid) && w < 300) begin
      tick();
      w++;
    end
    chk("drain_timeout", busy, 0);
    tick();
    tick();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_core_counter", core_counter, 0);
    chk("rst_core_key", core_key, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepted;
    logic xf;
    reset     = 1'b1;
    key_load  = 1'b0;
    key_in    = '0;
    iv_in     = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    exp_key   = '0;
    exp_ctr   = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk_reset_outputs();
    chk("rst_state", dut.state, IDLE);

    // Counter crossing 0xFF with back-to-back issue and latency check
    exp_key = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    exp_ctr = 64'h0000_0000_0000_00FE;
    load(exp_key, exp_ctr);
    chk("key_loaded", core_key, exp_key);
    chk("ready_after_key", in_ready, 1);
    chk_lat = 1'b1;
    send(64'h1111_2222_3333_4444, 1'b0);
    send(64'h5555_6666_7777_8888, 1'b0);
    send(64'h9999_AAAA_BBBB_CCCC, 1'b1);
    in_valid = 1'b0;
    chk("drain_state", dut.state, DRAIN);
    chk("drain_in_ready", in_ready, 0);
    wait_idle();
    chk_lat = 1'b0;
    chk("ready_after_drain", dut.state, READY);

    // 64-bit counter wrap
    exp_key = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
    exp_ctr = 64'hFFFF_FFFF_FFFF_FFFF;
    load(exp_key, exp_ctr);
    chk("reload_key", core_key, exp_key);
    send(64'hDEAD_BEEF_0000_0001, 1'b0);
    send(64'hDEAD_BEEF_0000_0002, 1'b1);
    in_valid = 1'b0;
    chk("wrap_counter_next", dut.counter, 64'h1);
    wait_idle();

    // Backpressure: credit limit caps acceptance at FIFO depth
    out_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = 64'hC0DE_0000_0000_0000 + 64'(i);
      in_last  = 1'b0;
      xf       = in_ready;
      tick();
      if (xf) begin
        sb.push_back('{data: in_data ^ exp_ctr ^ exp_key[63:0], last: 1'b0, t_edge: cyc});
        exp_ctr = exp_ctr + 64'd1;
        accepted++;
      end
    end
    in_valid = 1'b0;
    chk("accepted_count", accepted, DEPTH);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_fifo_count", dut.fifo_count, DEPTH);
    out_ready = 1'b1;
    wait_idle();
    chk("run_after_release", dut.state, RUN);
    chk("ready_after_release", in_ready, 1);

    // Five-block message ending with in_last
    for (int i = 0; i < 5; i++) send(64'hF00D_0000_0000_0000 + 64'(i), (i == 4));
    in_valid = 1'b0;
    chk("msg_drain_state", dut.state, DRAIN);
    chk("msg_drain_in_ready", in_ready, 0);
    wait_idle();
    chk("msg_ready_state", dut.state, READY);

    // key_load honoured in READY, ignored in RUN
    exp_key = 128'h1357_9BDF_2468_ACE0_1122_3344_5566_7788;
    exp_ctr = 64'h0000_0000_0000_1000;
    load(exp_key, exp_ctr);
    chk("ready_reload_key", core_key, exp_key);
    chk("ready_reload_ctr", dut.counter, 64'h1000);
    send(64'hAAAA_0000_0000_0001, 1'b0);
    send(64'hAAAA_0000_0000_0002, 1'b0);
    in_valid = 1'b0;
    load(128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 64'h5555);
    chk("run_key_kept", core_key, exp_key);
    chk("run_ctr_kept", dut.counter, 64'h1002);
    send(64'hAAAA_0000_0000_0003, 1'b1);
    wait_idle();

    // Reset in the middle of traffic
    for (int i = 0; i < 4; i++) send(64'hBEEF_0000_0000_0000 + 64'(i), 1'b0);
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    chk_reset_outputs();
    chk("midrst_state", dut.state, IDLE);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("midrst_no_out", out_valid, 0);
    end
    chk("midrst_busy", busy, 0);

    chk("sb_left", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
